// File: rtl/mul_mac_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_mac_stage_if
//  Purpose  : Bundle of the issue, multiplier and result handshakes of
//             mul_mac_stage. The slave modport is the stage itself. The
//             master modport is its environment: upstream, the multiplier
//             and downstream.
//  Revision : 1.0  initial release
// ============================================================================
interface mul_mac_stage_if #(
    parameter int ACC_W = 40
);
    // upstream request
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_a;
    logic [15:0]        in_b;
    logic [1:0]         in_op;
    // multiplier operands / product
    logic [15:0]        mul_a;
    logic [15:0]        mul_b;
    logic [31:0]        mul_p;
    // downstream result
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_acc;
    logic               out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_op, mul_p, out_ready,
        output in_ready, mul_a, mul_b, out_valid, out_acc, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_op, mul_p, out_ready,
        input  in_ready, mul_a, mul_b, out_valid, out_acc, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/mul_mac_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mul_mac_stage
//  Purpose  : Two-stage operand-issue / accumulate wrapper around an external
//             combinational 16x16 unsigned multiplier. Stage 1 registers the
//             operands toward the multiplier. Stage 2 folds the product into
//             an ACC_W-bit accumulator (MUL / MAC / MSU / CLR) and holds the
//             result for the downstream valid/ready handshake.
//  Options  : MAC_SAT_EN - when defined, MAC saturates at all-ones and MSU
//             clamps at zero. Otherwise both wrap modulo 2^ACC_W.
//  Revision : 1.0  initial release
// ============================================================================
module mul_mac_stage #(
    parameter int ACC_W = 40            // accumulator width, 33..64
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    mul_mac_stage_if.slave  bus
);

    localparam logic [1:0] c_op_mul = 2'b00;
    localparam logic [1:0] c_op_mac = 2'b01;
    localparam logic [1:0] c_op_msu = 2'b10;
    localparam logic [1:0] c_op_clr = 2'b11;

    // state
    logic               s1_valid_q, s1_valid_d;
    logic [15:0]        mul_a_q,    mul_a_d;
    logic [15:0]        mul_b_q,    mul_b_d;
    logic [1:0]         op_q,       op_d;
    logic [ACC_W-1:0]   acc_q,      acc_d;
    logic               ovf_q,      ovf_d;
    logic               out_valid_q, out_valid_d;

    // combinational helpers
    logic               w_in_ready;
    logic               w_fire;
    logic               w_accept;
    logic [ACC_W-1:0]   w_prod;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W:0]     w_diff;

    // Handshake. Stage 2 fires whenever its result slot is free or being
    // drained. Stage 1 can take a new request whenever it is empty or about
    // to hand off, which gives one op per cycle. in_ready stays low while
    // reset is asserted.
    always_comb begin
        w_fire     = s1_valid_q && (!out_valid_q || bus.out_ready);
        w_in_ready = rst_n && (!s1_valid_q || !out_valid_q || bus.out_ready);
        w_accept   = bus.in_valid && w_in_ready;
    end

    // Product zero-extension and the carry/borrow-producing add and subtract.
    always_comb begin
        w_prod = {{(ACC_W-32){1'b0}}, bus.mul_p};
        w_sum  = {1'b0, acc_q} + {1'b0, w_prod};
        w_diff = {1'b0, acc_q} - {1'b0, w_prod};
    end

    // Stage 1: capture operands on acceptance. Hold them while stalled.
    always_comb begin
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        op_d       = op_q;
        s1_valid_d = s1_valid_q;
        if (w_accept) begin
            mul_a_d    = bus.in_a;
            mul_b_d    = bus.in_b;
            op_d       = bus.in_op;
            s1_valid_d = 1'b1;
        end else if (w_fire) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2: accumulator update. Bit ACC_W of w_sum is the carry out and
    // bit ACC_W of w_diff is the borrow.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (w_fire) begin
            case (op_q)
                c_op_mul: begin
                    acc_d = w_prod;
                    ovf_d = 1'b0;
                end
                c_op_mac: begin
`ifdef MAC_SAT_EN
                    acc_d = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
                    acc_d = w_sum[ACC_W-1:0];
`endif
                    ovf_d = ovf_q | w_sum[ACC_W];
                end
                c_op_msu: begin
`ifdef MAC_SAT_EN
                    acc_d = w_diff[ACC_W] ? {ACC_W{1'b0}} : w_diff[ACC_W-1:0];
`else
                    acc_d = w_diff[ACC_W-1:0];
`endif
                    ovf_d = ovf_q | w_diff[ACC_W];
                end
                c_op_clr: begin
                    acc_d = {ACC_W{1'b0}};
                    ovf_d = 1'b0;
                end
                default: begin
                    acc_d = acc_q;
                    ovf_d = ovf_q;
                end
            endcase
        end
    end

    // Output valid: set on fire. Otherwise drop once the consumer takes it.
    always_comb begin
        out_valid_d = out_valid_q;
        if (w_fire) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            mul_a_q     <= 16'h0000;
            mul_b_q     <= 16'h0000;
            op_q        <= c_op_mul;
            acc_q       <= {ACC_W{1'b0}};
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Output drive. All outputs come straight from flops except in_ready.
    assign bus.in_ready  = w_in_ready;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: doc/mul_mac_stage.md
Name: mul_mac_stage

Overview:
- Operand-issue and accumulate stage wrapped around the combinational 16x16 unsigned multiplier in the execute datapath.
- Accepts operand pairs and an opcode over a valid/ready handshake.
- Registers the operands and drives them to the multiplier, then consumes the 32-bit product on the next cycle.
- Updates an ACC_W-bit accumulator (load, add, subtract or clear) and presents the result downstream over a valid/ready handshake.

Parameters:
- ACC_W, 40, accumulator width in bits; legal range 33..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream request valid.
- in_ready  output  1  stage can accept a request this cycle.
- in_a  input  16  operand A, unsigned.
- in_b  input  16  operand B, unsigned.
- in_op  input  2  00 MUL (acc=P), 01 MAC (acc+=P), 10 MSU (acc-=P), 11 CLR (acc=0).
- mul_a  output  16  registered operand A, to the multiplier.
- mul_b  output  16  registered operand B, to the multiplier.
- mul_p  input  32  product returned combinationally from the multiplier.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  accumulator value after the last executed op.
- out_ovf  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, mul_a=0, mul_b=0, op register=00, acc=0, out_acc=0, out_ovf=0, out_valid=0. in_ready=1 once reset is released.
- Reset mid-operation discards any in-flight request and result. No output glitches to a partial value.
- Stage 1 (issue):
  - Acceptance is in_valid && in_ready at a rising edge.
  - On acceptance, latch in_a→mul_a, in_b→mul_b and in_op, and set s1_valid.
  - mul_a/mul_b hold their value while s1_valid is stalled.
- Stage 2 (accumulate):
  - Fires when s1_valid && (!out_valid || out_ready).
  - P = mul_p zero-extended to ACC_W.
  - MUL: acc=P, ovf cleared.
  - MAC: acc=acc+P mod 2^ACC_W; ovf |= carry out.
  - MSU: acc=acc-P mod 2^ACC_W; ovf |= borrow.
  - CLR: acc=0, ovf=0; mul_p is ignored.
  - On fire: out_acc/out_ovf take the new values, out_valid=1, and s1_valid clears unless a new request is accepted on the same edge.
- Handshake rules:
  - in_ready = !s1_valid || !out_valid || out_ready (combinational, full throughput).
  - out_valid drops on the edge where out_ready=1 and stage 2 does not fire.
  - out_acc and out_ovf are stable while out_valid && !out_ready.
- Latency:
  - Accepted at edge N; product observed during cycle N+1.
  - out_valid=1 and out_acc updated after edge N+1.
  - Back-to-back acceptance at 1 op/cycle when out_ready is held high.
- Simultaneous events:
  - Accept + fire on the same edge: stage 1 loads the new operands while stage 2 consumes the old ones.
  - out_ready + fire on the same edge: the new result replaces the old one and out_valid stays 1.
- Boundary cases:
  - 0xFFFF*0xFFFF = 0xFFFE0001.
  - Accumulator wraps modulo 2^ACC_W in the default build.
  - MSU below zero wraps and sets out_ovf.
  - out_ovf remains set until a MUL or CLR executes.

Optional Feature:
- MAC_SAT_EN defined:
  - MAC saturates at 2^ACC_W-1 instead of wrapping.
  - MSU clamps at 0 instead of wrapping.
  - out_ovf still sets on any clamp.
- MAC_SAT_EN undefined: modular wrap as specified in Behaviour; no saturation logic synthesised.

Test Plan:
- Reset, then MUL 0x0003*0x0005 with out_ready=1 → mul_a=0x0003 and mul_b=0x0005 one edge after acceptance; out_valid next edge; out_acc=15, out_ovf=0.
- Streamed ops with in_valid/out_ready=1 every cycle:
  - MUL 0xFFFF*0xFFFF → out_acc=0xFFFE0001.
  - MAC 0xFFFF*0xFFFF → out_acc=0x1FFFC0002.
  - Results appear on consecutive cycles and in_ready stays 1.
- Backpressure: out_ready=0 with 3 requests offered → two accepted, in_ready=0 thereafter. out_acc is held stable; after out_ready=1, all three results emerge in order.
- Underflow: CLR, then MSU 1*1 →
  - default build: out_acc=2^40-1, out_ovf=1.
  - MAC_SAT_EN build: out_acc=0, out_ovf=1.
  - A following MUL 2*2 gives out_acc=4, out_ovf=0.
- Overflow wrap, ACC_W=33:
  - MAC 0xFFFF*0xFFFF three times from acc=0 → out_acc=(3*0xFFFE0001) mod 2^33=0x0FFFA0003, out_ovf=1.
  - MAC_SAT_EN build: out_acc=0x1FFFFFFFF.
- Assert rst_n=0 asynchronously while s1_valid=1 and out_valid=1 → all outputs are 0 immediately. After release, the first op MAC 2*3 yields out_acc=6.
